// File: rtl/cpu_defs.sv
// Shared CSR addresses, timer config layout and ESTAT.IS bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_defs;

    localparam int TIMER_WID = 32;

    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    typedef struct packed {
        logic [TIMER_WID-3:0] initval;
        logic                 periodic;
        logic                 en;
    } tcfg_t;

    localparam int IS_SWI_LSB = 0;
    localparam int IS_HWI_LSB = 2;
    localparam int IS_TI      = 11;
    localparam int IS_IPI     = 12;
    localparam int IS_WID     = 13;

endpackage

// File: rtl/intr_sync.sv
// Multi-flop synchronizer for asynchronous interrupt lines.
// Latency: STAGES cycles from input change to q.
// Backpressure: none; level lines are sampled every cycle.
module intr_sync #(
    parameter int STAGES = 2,
    parameter int WID    = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WID-1:0] d,
    output logic [WID-1:0] q
);

    logic [WID-1:0] stg_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/csr_timer_intr_ctrl.sv
// Constant-timer CSRs, TI/HWI/IPI status sources and interrupt request handshake.
// Latency: timeout->intr_req 2 cycles; hwi_in->intr_req HWI_SYNC+1 cycles.
// Backpressure: intr_req held until intr_ack or until the pending condition goes away.
module csr_timer_intr_ctrl #(
    parameter int          TIMER_WID = 32,
    parameter logic [31:0] TID_RST   = 32'h0,
    parameter int          HWI_SYNC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wr_data,
    output logic [31:0] csr_rd_data,
    input  logic [7:0]  hwi_in,
    input  logic        ipi_in,
    input  logic        crmd_ie,
    input  logic [12:0] ecfg_lie,
    input  logic [1:0]  estat_swi,
    output logic        is_ti,
    output logic [7:0]  is_hwi,
    output logic        is_ipi,
    output logic        intr_req,
    input  logic        intr_ack
);
    import cpu_defs::*;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} hs_state_e;

    logic [31:0]          tid_q;
    logic [TIMER_WID-3:0] initval_q;
    logic                 periodic_q;
    logic                 en_q;
    logic [TIMER_WID-1:0] tval_q;
    logic                 timer_active_q;
    logic                 is_ti_q;
    hs_state_e            state_q;
    logic                 intr_req_q;

    logic                 tid_we;
    logic                 tcfg_we;
    logic                 ticlr_we;
    logic                 timeout;
    logic                 pending;
    logic [IS_WID-1:0]    is_vec;
    logic [8:0]           sync_q;

    assign tid_we   = csr_we && (csr_addr == CSR_TID);
    assign tcfg_we  = csr_we && (csr_addr == CSR_TCFG);
    assign ticlr_we = csr_we && (csr_addr == CSR_TICLR);
    assign timeout  = timer_active_q && (tval_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid_q <= TID_RST;
        end else if (tid_we) begin
            tid_q <= csr_wr_data;
        end
    end

    // A TCFG write overrides a same-cycle reload or freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            initval_q      <= '0;
            periodic_q     <= 1'b0;
            en_q           <= 1'b0;
            tval_q         <= '0;
            timer_active_q <= 1'b0;
        end else if (tcfg_we) begin
            initval_q      <= csr_wr_data[TIMER_WID-1:2];
            periodic_q     <= csr_wr_data[1];
            en_q           <= csr_wr_data[0];
            tval_q         <= {csr_wr_data[TIMER_WID-1:2], 2'b00};
            timer_active_q <= csr_wr_data[0];
        end else if (timer_active_q) begin
            if (tval_q != '0) begin
                tval_q <= tval_q - TIMER_WID'(1);
            end else if (periodic_q) begin
                tval_q <= {initval_q, 2'b00};
            end else begin
                tval_q         <= '1;
                timer_active_q <= 1'b0;
            end
        end
    end

    // Set beats clear when a timeout and a TICLR write coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_ti_q <= 1'b0;
        end else if (timeout) begin
            is_ti_q <= 1'b1;
        end else if (ticlr_we && csr_wr_data[0]) begin
            is_ti_q <= 1'b0;
        end
    end

    always_comb begin
        csr_rd_data = '0;
        case (csr_addr)
            CSR_TID:  csr_rd_data = tid_q;
            CSR_TCFG: csr_rd_data[TIMER_WID-1:0] = {initval_q, periodic_q, en_q};
            CSR_TVAL: csr_rd_data[TIMER_WID-1:0] = tval_q;
            default:  csr_rd_data = '0;
        endcase
    end

    intr_sync #(
        .STAGES (HWI_SYNC),
        .WID    (9)
    ) u_intr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({ipi_in, hwi_in}),
        .q     (sync_q)
    );

    assign is_hwi = sync_q[7:0];
    assign is_ipi = sync_q[8];
    assign is_ti  = is_ti_q;

    always_comb begin
        is_vec                   = '0;
        is_vec[IS_SWI_LSB +: 2]  = estat_swi;
        is_vec[IS_HWI_LSB +: 8]  = is_hwi;
        is_vec[IS_TI]            = is_ti_q;
        is_vec[IS_IPI]           = is_ipi;
    end

    assign pending = crmd_ie && |(is_vec & ecfg_lie);

    // HOLD gives the exception stage's CRMD.IE clear one cycle to land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            intr_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending) begin
                        state_q    <= ST_REQ;
                        intr_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (intr_ack) begin
                        state_q    <= ST_HOLD;
                        intr_req_q <= 1'b0;
                    end else if (!pending) begin
                        state_q    <= ST_IDLE;
                        intr_req_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    state_q    <= ST_IDLE;
                    intr_req_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    intr_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign intr_req = intr_req_q;

endmodule

// File: tb/tb_csr_timer_intr_ctrl.sv
// Bench for csr_timer_intr_ctrl: directed scenarios plus a randomized run against
// an arithmetic timer/interrupt model. Inputs change and outputs are sampled on negedge.
module tb_csr_timer_intr_ctrl;

    localparam logic [13:0] A_TID   = 14'h040;
    localparam logic [13:0] A_TCFG  = 14'h041;
    localparam logic [13:0] A_TVAL  = 14'h042;
    localparam logic [13:0] A_TICLR = 14'h044;
    localparam int          SYNC    = 2;

    logic        clk;
    logic        rst_n;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wr_data;
    logic [31:0] csr_rd_data;
    logic [7:0]  hwi_in;
    logic        ipi_in;
    logic        crmd_ie;
    logic [12:0] ecfg_lie;
    logic [1:0]  estat_swi;
    logic        is_ti;
    logic [7:0]  is_hwi;
    logic        is_ipi;
    logic        intr_req;
    logic        intr_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // Timer model: configuration written at cycle m_w (first cycle TVAL shows the reload).
    int m_w;
    int m_ci;
    bit m_cp;
    bit m_ce;

    csr_timer_intr_ctrl #(
        .TIMER_WID (32),
        .TID_RST   (32'h0),
        .HWI_SYNC  (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_addr    (csr_addr),
        .csr_we      (csr_we),
        .csr_wr_data (csr_wr_data),
        .csr_rd_data (csr_rd_data),
        .hwi_in      (hwi_in),
        .ipi_in      (ipi_in),
        .crmd_ie     (crmd_ie),
        .ecfg_lie    (ecfg_lie),
        .estat_swi   (estat_swi),
        .is_ti       (is_ti),
        .is_hwi      (is_hwi),
        .is_ipi      (is_ipi),
        .intr_req    (intr_req),
        .intr_ack    (intr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_tval(int c);
        int d   = c - m_w;
        int top = 4 * m_ci;
        if (!m_ce) return 32'(top);
        if (m_cp)  return 32'(top - d % (top + 1));
        if (d <= top) return 32'(top - d);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic bit model_timeout(int c);
        int d   = c - m_w;
        int top = 4 * m_ci;
        if (!m_ce) return 1'b0;
        if (m_cp)  return (d % (top + 1)) == top;
        return d == top;
    endfunction

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        csr_addr = a;
        #1;
        d = csr_rd_data;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_we      = 1'b1;
        csr_addr    = a;
        csr_wr_data = d;
        @(negedge clk);
        csr_we      = 1'b0;
        csr_wr_data = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if ({is_ti, is_hwi, is_ipi} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %b required 0", {is_ti, is_hwi, is_ipi});
        end
        rd(A_TID, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_tid: got %h required 00000000", d);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rd(A_TCFG, d);
            n_tests++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_tcfg cycle %0d: got %h required 00000000", i, d);
            end
            rd(A_TVAL, d);
            n_tests++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_tval cycle %0d: got %h required 00000000", i, d);
            end
            n_tests++;
            if (intr_req !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_req cycle %0d: got %b required 0", i, intr_req);
            end
        end
        rd(A_TICLR, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ticlr_rd: got %h required 00000000", d);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        wr(A_TCFG, 32'h0000_0011);
        for (int k = 0; k <= 16; k++) begin
            rd(A_TVAL, d);
            n_tests++;
            if (d !== 32'(16 - k)) begin
                n_fail++;
                $display("FAIL oneshot_tval k=%0d: got %h required %h", k, d, 32'(16 - k));
            end
            n_tests++;
            if (is_ti !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot_ti_early k=%0d: got %b required 0", k, is_ti);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            rd(A_TVAL, d);
            n_tests++;
            if (d !== 32'hFFFF_FFFF) begin
                n_fail++;
                $display("FAIL oneshot_freeze k=%0d: got %h required ffffffff", k, d);
            end
            n_tests++;
            if (is_ti !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_ti_set k=%0d: got %b required 1", k, is_ti);
            end
            @(negedge clk);
        end
        rd(A_TCFG, d);
        n_tests++;
        if (d !== 32'h0000_0011) begin
            n_fail++;
            $display("FAIL oneshot_tcfg_rd: got %h required 00000011", d);
        end
        wr(A_TICLR, 32'hFFFF_FFFE);
        n_tests++;
        if (is_ti !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_ticlr_bit0_zero: got %b required 1", is_ti);
        end
        wr(A_TICLR, 32'h1);
        n_tests++;
        if (is_ti !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_ticlr: got %b required 0", is_ti);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        bit          ti_exp;
        bit          clr;
        ti_exp = 1'b0;
        wr(A_TCFG, 32'h0000_0013);
        for (int k = 0; k < 53; k++) begin
            csr_we      = 1'b0;
            csr_wr_data = 32'h0;
            rd(A_TVAL, d);
            n_tests++;
            if (d !== 32'(16 - k % 17)) begin
                n_fail++;
                $display("FAIL per_tval k=%0d: got %h required %h", k, d, 32'(16 - k % 17));
            end
            n_tests++;
            if (is_ti !== ti_exp) begin
                n_fail++;
                $display("FAIL per_ti k=%0d: got %b required %b", k, is_ti, ti_exp);
            end
            // k=50 lands on a timeout: the clear must lose.
            clr = (k == 22) || (k == 50);
            if (clr) begin
                csr_we      = 1'b1;
                csr_addr    = A_TICLR;
                csr_wr_data = 32'h1;
            end
            if (k % 17 == 16) ti_exp = 1'b1;
            else if (clr)     ti_exp = 1'b0;
            @(negedge clk);
        end
        csr_we = 1'b0;
        wr(A_TCFG, 32'h0);
        wr(A_TICLR, 32'h1);
        rd(A_TVAL, d);
        n_tests++;
        if (d !== 32'h0 || is_ti !== 1'b0) begin
            n_fail++;
            $display("FAIL per_stop: tval %h ti %b required 0 0", d, is_ti);
        end
    endtask

    task automatic test_handshake();
        int hold_n;
        crmd_ie  = 1'b1;
        ecfg_lie = 13'h0800;
        wr(A_TCFG, 32'h0000_0011);
        for (int k = 0; k <= 17; k++) begin
            n_tests++;
            if (intr_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hs_early k=%0d: got %b required 0", k, intr_req);
            end
            @(negedge clk);
        end
        n_tests++;
        if (intr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_rise: got %b required 1", intr_req);
        end
        hold_n = $urandom_range(2, 6);
        for (int k = 0; k < hold_n; k++) begin
            @(negedge clk);
            n_tests++;
            if (intr_req !== 1'b1) begin
                n_fail++;
                $display("FAIL hs_hold_req k=%0d: got %b required 1", k, intr_req);
            end
        end
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
        n_tests++;
        if (intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_drop: got %b required 0", intr_req);
        end
        @(negedge clk);
        n_tests++;
        if (intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_hold_cycle: got %b required 0", intr_req);
        end
        @(negedge clk);
        n_tests++;
        if (intr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_rereq: got %b required 1", intr_req);
        end
        crmd_ie = 1'b0;
        @(negedge clk);
        n_tests++;
        if (intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_ie_withdraw: got %b required 0", intr_req);
        end
        intr_ack = 1'b1;
        repeat (2) @(negedge clk);
        intr_ack = 1'b0;
        n_tests++;
        if (intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_idle_ack: got %b required 0", intr_req);
        end
        wr(A_TICLR, 32'h1);
        wr(A_TCFG, 32'h0);
        ecfg_lie = 13'h0;
    endtask

    task automatic test_masking();
        crmd_ie  = 1'b1;
        ecfg_lie = 13'h0010;
        hwi_in   = 8'h08;
        repeat (SYNC) @(negedge clk);
        n_tests++;
        if (is_hwi !== 8'h08) begin
            n_fail++;
            $display("FAIL mask_sync: got %h required 08", is_hwi);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_blocked: got %b required 0", intr_req);
        end
        hwi_in = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if (is_hwi !== 8'h00) begin
            n_fail++;
            $display("FAIL mask_level: got %h required 00", is_hwi);
        end
        ecfg_lie = 13'h0020;
        hwi_in   = 8'h08;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(negedge clk);
            n_tests++;
            if (intr_req !== (k == SYNC + 1)) begin
                n_fail++;
                $display("FAIL mask_latency k=%0d: got %b required %b", k, intr_req, k == SYNC + 1);
            end
        end
        crmd_ie = 1'b0;
        @(negedge clk);
        n_tests++;
        if (intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_ie_drop: got %b required 0", intr_req);
        end
        hwi_in   = 8'h00;
        ecfg_lie = 13'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] d, m_tid, exp_rd, wdat;
        logic [13:0] addr;
        logic [8:0]  hist [$];
        logic [12:0] vec;
        bit          m_ti, m_req, m_hold, n_req, pend, tout;
        int          act;
        logic [13:0] rd_tab [6];
        rd_tab = '{A_TID, A_TCFG, A_TVAL, A_TICLR, 14'h043, 14'h000};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_w = 0; m_ci = 0; m_cp = 1'b0; m_ce = 1'b0;
        m_tid = 32'h0; m_ti = 1'b0; m_req = 1'b0; m_hold = 1'b0;
        for (int i = 0; i < SYNC; i++) hist.push_back(9'h0);
        for (int c = 0; c < 400; c++) begin
            csr_we = 1'b0;
            rd(A_TVAL, d);
            n_tests++;
            if (d !== model_tval(c)) begin
                n_fail++;
                $display("FAIL rand_tval c=%0d: got %h required %h", c, d, model_tval(c));
            end
            n_tests++;
            if (is_ti !== m_ti) begin
                n_fail++;
                $display("FAIL rand_ti c=%0d: got %b required %b", c, is_ti, m_ti);
            end
            n_tests++;
            if ({is_ipi, is_hwi} !== hist[c]) begin
                n_fail++;
                $display("FAIL rand_sync c=%0d: got %h required %h", c, {is_ipi, is_hwi}, hist[c]);
            end
            n_tests++;
            if (intr_req !== m_req) begin
                n_fail++;
                $display("FAIL rand_req c=%0d: got %b required %b", c, intr_req, m_req);
            end
            if ($urandom_range(0, 3) == 0) {ipi_in, hwi_in} = 9'($urandom);
            if ($urandom_range(0, 7) == 0) crmd_ie   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) ecfg_lie  = 13'($urandom);
            if ($urandom_range(0, 7) == 0) estat_swi = 2'($urandom);
            intr_ack = ($urandom_range(0, 3) == 0);
            act  = $urandom_range(0, 15);
            wdat = $urandom;
            case (act)
                0, 1: begin
                    wdat = {27'h0, 3'($urandom), 2'($urandom)};
                    addr = A_TCFG;
                end
                2, 3: addr = A_TICLR;
                4:    addr = A_TID;
                5:    addr = A_TVAL;
                6:    addr = 14'h043;
                default: addr = rd_tab[$urandom_range(0, 5)];
            endcase
            csr_we      = (act <= 6);
            csr_wr_data = wdat;
            rd(addr, d);
            if (addr == A_TID)       exp_rd = m_tid;
            else if (addr == A_TCFG) exp_rd = 32'(m_ci * 4 + (m_cp ? 2 : 0) + (m_ce ? 1 : 0));
            else if (addr == A_TVAL) exp_rd = model_tval(c);
            else                     exp_rd = 32'h0;
            n_tests++;
            if (d !== exp_rd) begin
                n_fail++;
                $display("FAIL rand_rd c=%0d addr=%h: got %h required %h", c, addr, d, exp_rd);
            end
            vec  = {hist[c][8], m_ti, 1'b0, hist[c][7:0], estat_swi};
            pend = crmd_ie && |(vec & ecfg_lie);
            n_req  = m_req ? (!intr_ack && pend) : (!m_hold && pend);
            m_hold = m_req && intr_ack;
            m_req  = n_req;
            tout   = model_timeout(c);
            if (tout) m_ti = 1'b1;
            else if (csr_we && addr == A_TICLR && wdat[0]) m_ti = 1'b0;
            if (csr_we && addr == A_TID) m_tid = wdat;
            if (csr_we && addr == A_TCFG) begin
                m_w  = c + 1;
                m_ci = int'(wdat[31:2]);
                m_cp = wdat[1];
                m_ce = wdat[0];
            end
            hist.push_back({ipi_in, hwi_in});
            @(negedge clk);
        end
        csr_we = 1'b0; intr_ack = 1'b0; crmd_ie = 1'b0;
        ecfg_lie = 13'h0; estat_swi = 2'h0; hwi_in = 8'h0; ipi_in = 1'b0;
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        ecfg_lie = 13'h1FFF;
        crmd_ie  = 1'b1;
        hwi_in   = 8'hFF;
        ipi_in   = 1'b1;
        wr(A_TID, 32'hA5A5_0001);
        wr(A_TCFG, 32'h0000_0011);
        repeat (8) @(negedge clk);
        rd(A_TVAL, d);
        n_tests++;
        if (d !== 32'h8 || intr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: tval %h req %b required 00000008 1", d, intr_req);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({is_ti, is_hwi, is_ipi, intr_req} !== 11'h0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %b required 0", {is_ti, is_hwi, is_ipi, intr_req});
        end
        rd(A_TVAL, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_tval_rst: got %h required 00000000", d);
        end
        hwi_in = 8'h0; ipi_in = 1'b0; crmd_ie = 1'b0; ecfg_lie = 13'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rd(A_TVAL, d);
        n_tests++;
        if (d !== 32'h0 || is_ti !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_resume: tval %h ti %b required 0 0", d, is_ti);
        end
        rd(A_TCFG, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_tcfg: got %h required 00000000", d);
        end
        rd(A_TID, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_tid: got %h required 00000000", d);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        csr_addr    = 14'h0;
        csr_we      = 1'b0;
        csr_wr_data = 32'h0;
        hwi_in      = 8'h0;
        ipi_in      = 1'b0;
        crmd_ie     = 1'b0;
        ecfg_lie    = 13'h0;
        estat_swi   = 2'h0;
        intr_ack    = 1'b0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_handshake();
        test_masking();
        test_random();
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule
